// File: rtl/layer1_event_sequencer.sv
// Layer-1 frame sequencer: drains event indices, drives fetch/load/accumulate per event, then ReLU/capture/hold.
// Optional LAYER1_SEQ_PERF_EN macro adds the frameCycles performance counter output.
module layer1_event_sequencer #(
   parameter int ADDR_W     = 10,
   parameter int FETCH_LAT  = 1,
   parameter int MAX_EVENTS = 784,
   parameter int CNT_W      = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inputsReady,
   input  logic              queueEmpty,
   input  logic [ADDR_W-1:0] queueOut,
   output logic              dequeue,
   input  logic              cfgWrite,
   input  logic [ADDR_W-1:0] cfgAddr,
   output logic [ADDR_W-1:0] nodeAddress,
   output logic              bufferLoad,
   output logic              accumEn,
   output logic              accumClr,
   output logic              reluTrigger,
   output logic              outputCapture,
   output logic              outputsReady,
   input  logic              outputsRecieved,
   output logic              busy,
   output logic [CNT_W-1:0]  eventCount,
`ifdef LAYER1_SEQ_PERF_EN
   output logic [15:0]       frameCycles,
`endif
   output logic              overflow
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FETCH,
      S_WAIT,
      S_ACCUM,
      S_RELU,
      S_CAPTURE,
      S_HOLD
   } state_t;

   localparam logic [2:0]       WAIT_INIT = 3'(FETCH_LAT - 1);
   localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_EVENTS);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        wait_q, wait_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              ready_q, ready_d;
   logic [CNT_W-1:0]  count_inc;

   assign count_inc = count_q + CNT_W'(1);

   // State register and datapath flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wait_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wait_q  <= wait_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         ready_q <= ready_d;
      end
   end

   // Next-state logic; a configuration write freezes every compute step.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (inputsReady && !cfgWrite) begin
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (!cfgWrite) begin
               state_d = queueEmpty ? S_RELU : S_WAIT;
            end
         end
         S_WAIT: begin
            if (!cfgWrite && (wait_q == 3'd0)) begin
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (!cfgWrite) begin
               state_d = (count_inc == MAX_CNT) ? S_RELU : S_FETCH;
            end
         end
         S_RELU: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (outputsRecieved) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      addr_d  = addr_q;
      wait_d  = wait_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      ready_d = (state_d == S_HOLD);
      case (state_q)
         S_CLEAR: begin
            count_d = '0;
            ovf_d   = 1'b0;
         end
         S_FETCH: begin
            if (!cfgWrite && !queueEmpty) begin
               addr_d = queueOut;
               wait_d = WAIT_INIT;
            end
         end
         S_WAIT: begin
            // A stalled fetch restarts its full latency: the bus was lent to the config write.
            if (cfgWrite) begin
               wait_d = WAIT_INIT;
            end else if (wait_q != 3'd0) begin
               wait_d = wait_q - 3'd1;
            end
         end
         S_ACCUM: begin
            if (!cfgWrite) begin
               count_d = count_inc;
               if (count_inc == MAX_CNT) begin
                  ovf_d = 1'b1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // Output decode; pulses are suppressed during the reset cycle so the queue is never popped then.
   always_comb begin
      dequeue       = 1'b0;
      bufferLoad    = 1'b0;
      accumEn       = 1'b0;
      accumClr      = 1'b0;
      reluTrigger   = 1'b0;
      outputCapture = 1'b0;
      if (!reset) begin
         case (state_q)
            S_CLEAR:   accumClr      = 1'b1;
            S_FETCH:   dequeue       = !cfgWrite && !queueEmpty;
            S_WAIT:    bufferLoad    = !cfgWrite && (wait_q == 3'd0);
            S_ACCUM:   accumEn       = !cfgWrite;
            S_RELU:    reluTrigger   = 1'b1;
            S_CAPTURE: outputCapture = 1'b1;
            default: begin
            end
         endcase
      end
   end

   assign nodeAddress  = cfgWrite ? cfgAddr : addr_q;
   assign outputsReady = ready_q;
   assign busy         = (state_q != S_IDLE);
   assign eventCount   = count_q;
   assign overflow     = ovf_q;

`ifdef LAYER1_SEQ_PERF_EN
   logic [15:0] cycles_q, cycles_d;

   // The CLEAR cycle restarts the count at one so CLEAR itself is included.
   always_comb begin
      cycles_d = cycles_q;
      case (state_q)
         S_CLEAR: cycles_d = 16'd1;
         S_FETCH, S_WAIT, S_ACCUM, S_RELU, S_CAPTURE: begin
            if (cycles_q != 16'hFFFF) begin
               cycles_d = cycles_q + 16'd1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycles_q <= '0;
      end else begin
         cycles_q <= cycles_d;
      end
   end

   assign frameCycles = cycles_q;
`endif

endmodule

// File: tb/tb_layer1_event_sequencer.sv
// Scoreboard bench for layer1_event_sequencer: a queue model feeds events, a monitor checks every DUT pulse.
module tb_layer1_event_sequencer;
   localparam int ADDR_W     = 10;
   localparam int FETCH_LAT  = 1;
   localparam int MAX_EVENTS = 4;
   localparam int CNT_W      = 10;

   logic              clk = 1'b0;
   logic              reset, inputsReady, queueEmpty, dequeue, cfgWrite;
   logic [ADDR_W-1:0] queueOut, cfgAddr, nodeAddress;
   logic              bufferLoad, accumEn, accumClr, reluTrigger, outputCapture;
   logic              outputsReady, outputsRecieved, busy, overflow;
   logic [CNT_W-1:0]  eventCount;
`ifdef LAYER1_SEQ_PERF_EN
   logic [15:0]       frameCycles;
`endif

   layer1_event_sequencer #(
      .ADDR_W(ADDR_W), .FETCH_LAT(FETCH_LAT), .MAX_EVENTS(MAX_EVENTS), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .inputsReady(inputsReady), .queueEmpty(queueEmpty),
      .queueOut(queueOut), .dequeue(dequeue), .cfgWrite(cfgWrite), .cfgAddr(cfgAddr),
      .nodeAddress(nodeAddress), .bufferLoad(bufferLoad), .accumEn(accumEn),
      .accumClr(accumClr), .reluTrigger(reluTrigger), .outputCapture(outputCapture),
      .outputsReady(outputsReady), .outputsRecieved(outputsRecieved), .busy(busy),
      .eventCount(eventCount),
`ifdef LAYER1_SEQ_PERF_EN
      .frameCycles(frameCycles),
`endif
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int count;
      bit ovf;
      int lat;
   } frame_t;

   int     checks = 0;
   int     errors = 0;
   int     ev_q[$];
   int     exp_acc[$];
   frame_t exp_frame[$];
   bit     pop_pending = 1'b0;
   bit     last_deq = 1'b0;
   int     deq_total = 0;
   int     stall_extra = 0;
   int     cyc = 0;
   int     clr_cyc = 0;
   bit     prev_capture = 1'b0, prev_ready = 1'b0, prev_ack = 1'b0;

   task automatic chk(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Upstream show-ahead queue model: pops whatever the DUT dequeued in the previous cycle.
   initial begin
      queueEmpty = 1'b1;
      queueOut   = '0;
      forever begin
         @(posedge clk);
         if (pop_pending && ev_q.size() > 0) ev_q.delete(0);
         #1;
         queueEmpty = (ev_q.size() == 0);
         queueOut   = queueEmpty ? '0 : ADDR_W'(ev_q[0]);
      end
   end

   // Monitor: compares every observed pulse against the scoreboard queues.
   initial begin
      frame_t f;
      forever begin
         @(negedge clk);
         cyc++;
         pop_pending = dequeue;
         last_deq    = dequeue;
         if (reset) begin
            chk(!(dequeue || bufferLoad || accumEn || accumClr || reluTrigger || outputCapture),
                "pulses_in_reset", int'(dequeue), 0);
            prev_capture = 1'b0;
            prev_ready   = 1'b0;
            prev_ack     = 1'b0;
         end else begin
            chk($countones({dequeue, bufferLoad, accumEn, accumClr, reluTrigger, outputCapture}) <= 1,
                "pulse_onehot",
                $countones({dequeue, bufferLoad, accumEn, accumClr, reluTrigger, outputCapture}), 1);
            if (cfgWrite) begin
               chk(nodeAddress == cfgAddr, "cfg_addr_mux", int'(nodeAddress), int'(cfgAddr));
               chk(!bufferLoad && !accumEn && !dequeue, "cfg_stall_quiet",
                   int'({dequeue, bufferLoad, accumEn}), 0);
            end
            if (dequeue) begin
               deq_total++;
               chk(!queueEmpty, "deq_nonempty", int'(queueEmpty), 0);
            end
            if (accumClr) begin
               clr_cyc     = cyc;
               stall_extra = 0;
            end
            if (bufferLoad) begin
               if (exp_acc.size() == 0) chk(1'b0, "bufload_unexpected", 1, 0);
               else chk(nodeAddress == ADDR_W'(exp_acc[0]), "bufload_addr", int'(nodeAddress), exp_acc[0]);
            end
            if (accumEn) begin
               if (exp_acc.size() == 0) chk(1'b0, "accum_unexpected", 1, 0);
               else begin
                  chk(nodeAddress == ADDR_W'(exp_acc[0]), "accum_addr", int'(nodeAddress), exp_acc[0]);
                  exp_acc.delete(0);
               end
            end
            if (reluTrigger) begin
               if (exp_frame.size() == 0) chk(1'b0, "relu_unexpected", 1, 0);
               else begin
                  f = exp_frame[0];
                  exp_frame.delete(0);
                  chk(eventCount == CNT_W'(f.count), "event_count", int'(eventCount), f.count);
                  chk(overflow == f.ovf, "overflow_flag", int'(overflow), int'(f.ovf));
                  chk(cyc - clr_cyc == f.lat + stall_extra, "relu_latency",
                      cyc - clr_cyc, f.lat + stall_extra);
                  chk(exp_acc.size() == 0, "events_drained", exp_acc.size(), 0);
               end
            end
            if (prev_capture) chk(outputsReady, "ready_rise", int'(outputsReady), 1);
            if (prev_ready) begin
               if (prev_ack) chk(!outputsReady && !busy, "ready_fall", int'({outputsReady, busy}), 0);
               else chk(outputsReady, "ready_hold", int'(outputsReady), 1);
            end
            if (outputsReady) chk(!accumClr && busy, "hold_no_restart", int'({accumClr, busy}), 1);
            prev_capture = outputCapture;
            prev_ready   = outputsReady;
            prev_ack     = outputsRecieved;
         end
      end
   end

   // Reference model for a frame built from the current contents of the event queue.
   task automatic model_frame(output int m);
      frame_t f;
      int     n;
      n = ev_q.size();
      m = (n < MAX_EVENTS) ? n : MAX_EVENTS;
      for (int i = 0; i < m; i++) exp_acc.push_back(ev_q[i]);
      f.count = m;
      f.ovf   = (n >= MAX_EVENTS);
      f.lat   = 1 + m * (FETCH_LAT + 2) + ((m == MAX_EVENTS) ? 0 : 1);
      exp_frame.push_back(f);
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (outputsReady) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!ok) chk(1'b0, "ready_timeout", 0, 1);
   endtask

   task automatic run_frame(input int stall_len, input int ack_delay, input string tag);
      int m, deq0, left;
      bit ok, seen;
      model_frame(m);
      left = ev_q.size() - m;
      deq0 = deq_total;
      step();
      step();
      inputsReady = 1'b1;
      step();
      inputsReady = 1'b0;
      if (stall_len > 0 && m > 0) begin
         seen = 1'b0;
         for (int i = 0; i < 20; i++) begin
            if (last_deq) begin
               seen = 1'b1;
               break;
            end
            step();
         end
         chk(seen, "first_deq_timeout", int'(seen), 1);
         if (seen) begin
            cfgWrite    = 1'b1;
            stall_extra = stall_extra + stall_len;
            repeat (stall_len) step();
            cfgWrite = 1'b0;
            cfgAddr  = ADDR_W'($urandom_range(0, 1023));
         end
      end
      wait_ready(ok);
      if (ok) begin
         repeat (ack_delay) step();
         outputsRecieved = 1'b1;
         step();
         outputsRecieved = 1'b0;
         step();
      end
      chk(deq_total - deq0 == m, "dequeue_count", deq_total - deq0, m);
      chk(ev_q.size() == left, "queue_left", ev_q.size(), left);
      $display("frame %s: expected %0d events, dequeued %0d, eventCount=%0d overflow=%0b stall=%0d",
               tag, m, deq_total - deq0, eventCount, overflow, stall_len);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  m, deq0, n;
      bit  ok;
      frame_t fb;
      reset           = 1'b1;
      inputsReady     = 1'b0;
      cfgWrite        = 1'b0;
      cfgAddr         = '0;
      outputsRecieved = 1'b0;
      repeat (3) step();
      chk(!busy, "rst_busy", int'(busy), 0);
      chk(!outputsReady, "rst_ready", int'(outputsReady), 0);
      chk(eventCount == '0, "rst_count", int'(eventCount), 0);
      chk(!overflow, "rst_overflow", int'(overflow), 0);
      chk(nodeAddress == '0, "rst_addr", int'(nodeAddress), 0);
      reset = 1'b0;
      step();

      ev_q = '{5, 17, 300};
      run_frame(0, 3, "basic");
      chk(eventCount == 10'd3, "idle_count_held", int'(eventCount), 3);

      ev_q.delete();
      run_frame(0, 0, "empty");
      chk(eventCount == 10'd0, "empty_count", int'(eventCount), 0);

      ev_q = '{8, 9, 10};
      cfgAddr = 10'h3FF;
      run_frame(4, 2, "cfg_stall");
      chk(eventCount == 10'd3, "stall_count", int'(eventCount), 3);

      ev_q = '{100, 101, 102, 103, 104, 105};
      run_frame(0, 1, "overflow");
      chk(overflow, "overflow_sticky", int'(overflow), 1);

      // Reset landing while the first event is in WAIT.
      ev_q = '{1, 2, 3};
      model_frame(m);
      deq0 = deq_total;
      step();
      inputsReady = 1'b1;
      step();
      inputsReady = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (last_deq) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      chk(ok, "rst_deq_timeout", int'(ok), 1);
      reset = 1'b1;
      exp_acc.delete();
      exp_frame.delete();
      step();
      reset = 1'b0;
      chk(!busy, "midrst_idle", int'(busy), 0);
      chk(eventCount == '0, "midrst_count", int'(eventCount), 0);
      chk(!(dequeue || bufferLoad || accumEn || outputsReady), "midrst_outputs",
          int'({dequeue, bufferLoad, accumEn, outputsReady}), 0);
      repeat (10) step();
      chk(deq_total - deq0 == 1, "midrst_deq", deq_total - deq0, 1);
      chk(ev_q.size() == 2, "midrst_queue_left", ev_q.size(), 2);
      $display("frame midreset: dequeued %0d, queue left %0d", deq_total - deq0, ev_q.size());

      // Ack withheld for 20 cycles with inputsReady held; the next (empty) frame starts after ack.
      ev_q = '{40, 41};
      model_frame(m);
      fb.count = 0;
      fb.ovf   = 1'b0;
      fb.lat   = 2;
      exp_frame.push_back(fb);
      step();
      inputsReady = 1'b1;
      wait_ready(ok);
      repeat (20) step();
      chk(outputsReady, "ack_hold_ready", int'(outputsReady), 1);
      outputsRecieved = 1'b1;
      step();
      outputsRecieved = 1'b0;
      chk(!busy && !outputsReady, "ack_to_idle", int'({busy, outputsReady}), 0);
      step();
      chk(accumClr, "restart_clear", int'(accumClr), 1);
      inputsReady = 1'b0;
      wait_ready(ok);
      outputsRecieved = 1'b1;
      step();
      outputsRecieved = 1'b0;
      step();
      chk(eventCount == '0, "restart_empty_count", int'(eventCount), 0);
      $display("frame ackhold: back-to-back frames, eventCount=%0d", eventCount);

      for (int k = 0; k < 40; k++) begin
         ev_q.delete();
         n = $urandom_range(0, 6);
         for (int i = 0; i < n; i++) ev_q.push_back($urandom_range(0, 1023));
         run_frame(($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0,
                   $urandom_range(0, 5), $sformatf("rand%0d", k));
      end

      chk(exp_acc.size() == 0, "sb_acc_empty", exp_acc.size(), 0);
      chk(exp_frame.size() == 0, "sb_frame_empty", exp_frame.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
